// File: rtl/tusca_uc_multicanal.sv
// TUSCA station control unit: round-robin scan of N DHT11 channels with
// bounded read retries, error frames and watchdog-guarded waits.
module tusca_uc_multicanal #(
  parameter int N_CANAIS       = 4,
  parameter int MAX_TENTATIVAS = 3,
  parameter int TIMEOUT_CICLOS = 50_000_000,
  localparam int CW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1,
  localparam int TW = $clog2(MAX_TENTATIVAS + 1),
  localparam int WW = $clog2(TIMEOUT_CICLOS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          definir_config,
  input  logic          fim_delay,
  input  logic          pronto_medida,
  input  logic          erro_medida,
  input  logic          pronto_config,
  input  logic          pronto_transmissao_medida,
  output logic          medir_dht11,
  output logic [CW-1:0] canal,
  output logic          zera_delay,
  output logic          conta_delay,
  output logic          receber_config,
  output logic          transmite_medida,
  output logic          transmite_erro,
  output logic          falha_transmissao,
  output logic [TW-1:0] db_tentativas,
  output logic [3:0]    db_estado
);

  typedef enum logic [3:0] {
    INICIAL            = 4'd0,
    MEDE               = 4'd1,
    ESPERA_MEDIDA      = 4'd2,
    RESETA_DELAY       = 4'd3,
    ESPERA_DELAY       = 4'd4,
    PEDIR_CONFIG       = 4'd5,
    ESPERA_CONFIG      = 4'd6,
    TRANSMITE_MEDIDA   = 4'd7,
    ESPERA_TRANSMISSAO = 4'd8,
    PROXIMO_CANAL      = 4'd9,
    TRANSMITE_ERRO     = 4'd10,
    RETENTA            = 4'd11
  } estado_t;

  localparam logic [CW-1:0] CANAL_ULT = CW'(N_CANAIS - 1);
  localparam logic [TW-1:0] TENT_ULT  = TW'(MAX_TENTATIVAS - 1);
  localparam logic [WW-1:0] WD_ULT    = WW'(TIMEOUT_CICLOS - 1);

  estado_t       estado, prox;
  logic [TW-1:0] tentativas;
  logic [WW-1:0] wd;
  logic          wd_fim;
  logic          inc_tent;
  logic          avanca;
  logic          set_falha;
  logic          em_espera;

  assign wd_fim    = (wd == WD_ULT);
  assign em_espera = (estado == ESPERA_MEDIDA) ||
                     (estado == ESPERA_TRANSMISSAO);

  always_comb begin
    prox      = estado;
    inc_tent  = 1'b0;
    avanca    = 1'b0;
    set_falha = 1'b0;
    unique case (estado)
      INICIAL:
        if (start) prox = MEDE;
      MEDE:
        prox = ESPERA_MEDIDA;
      ESPERA_MEDIDA:
        if (pronto_medida) prox = TRANSMITE_MEDIDA;
        else if (erro_medida || wd_fim)
          prox = (tentativas < TENT_ULT) ? RETENTA : TRANSMITE_ERRO;
      RETENTA: begin
        inc_tent = 1'b1;
        prox     = MEDE;
      end
      TRANSMITE_MEDIDA, TRANSMITE_ERRO:
        prox = ESPERA_TRANSMISSAO;
      ESPERA_TRANSMISSAO:
        if (pronto_transmissao_medida) prox = PROXIMO_CANAL;
        else if (wd_fim) begin
          prox      = PROXIMO_CANAL;
          set_falha = 1'b1;
        end
      PROXIMO_CANAL: begin
        avanca = 1'b1;
        prox   = (canal == CANAL_ULT) ? RESETA_DELAY : MEDE;
      end
      RESETA_DELAY:
        prox = ESPERA_DELAY;
      ESPERA_DELAY:
        if (fim_delay) prox = MEDE;
        else if (definir_config) prox = PEDIR_CONFIG;
      PEDIR_CONFIG:
        prox = ESPERA_CONFIG;
      ESPERA_CONFIG:
        if (pronto_config) prox = RESETA_DELAY;
      default:
        prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado            <= INICIAL;
      canal             <= '0;
      tentativas        <= '0;
      wd                <= '0;
      falha_transmissao <= 1'b0;
    end else begin
      estado <= prox;
      // Free-running only while waiting, so every wait starts from zero
      wd     <= em_espera ? wd + WW'(1) : '0;
      if (inc_tent) tentativas <= tentativas + TW'(1);
      if (avanca) begin
        tentativas <= '0;
        canal      <= (canal == CANAL_ULT) ? '0 : canal + CW'(1);
      end
      if (set_falha) falha_transmissao <= 1'b1;
    end
  end

  assign medir_dht11      = (estado == MEDE);
  assign zera_delay       = (estado == RESETA_DELAY);
  assign conta_delay      = (estado == ESPERA_DELAY);
  assign receber_config   = (estado == PEDIR_CONFIG);
  assign transmite_medida = (estado == TRANSMITE_MEDIDA);
  assign transmite_erro   = (estado == TRANSMITE_ERRO);
  assign db_tentativas    = tentativas;
  assign db_estado        = estado;

endmodule

// File: tb/tb_tusca_uc_multicanal.sv
// Bench for tusca_uc_multicanal: directed vector table, hand-written
// timeout/reset sequences and a randomized event-level reference model.
module tb_tusca_uc_multicanal;

  localparam int N = 3;
  localparam int M = 2;
  localparam int T = 8;

  localparam logic [6:0] S  = 7'd64;
  localparam logic [6:0] F  = 7'd32;
  localparam logic [6:0] D  = 7'd16;
  localparam logic [6:0] PM = 7'd8;
  localparam logic [6:0] EM = 7'd4;
  localparam logic [6:0] PC = 7'd2;
  localparam logic [6:0] PT = 7'd1;

  localparam logic [5:0] MD = 6'd32;
  localparam logic [5:0] ZD = 6'd16;
  localparam logic [5:0] CD = 6'd8;
  localparam logic [5:0] RC = 6'd4;
  localparam logic [5:0] TM = 6'd2;
  localparam logic [5:0] TE = 6'd1;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, definir_config, fim_delay;
  logic       pronto_medida, erro_medida, pronto_config;
  logic       pronto_transmissao_medida;
  logic       medir_dht11, zera_delay, conta_delay, receber_config;
  logic       transmite_medida, transmite_erro, falha_transmissao;
  logic [1:0] canal;
  logic [1:0] db_tentativas;
  logic [3:0] db_estado;

  tusca_uc_multicanal #(
    .N_CANAIS(N), .MAX_TENTATIVAS(M), .TIMEOUT_CICLOS(T)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .definir_config(definir_config), .fim_delay(fim_delay),
    .pronto_medida(pronto_medida), .erro_medida(erro_medida),
    .pronto_config(pronto_config),
    .pronto_transmissao_medida(pronto_transmissao_medida),
    .medir_dht11(medir_dht11), .canal(canal),
    .zera_delay(zera_delay), .conta_delay(conta_delay),
    .receber_config(receber_config),
    .transmite_medida(transmite_medida),
    .transmite_erro(transmite_erro),
    .falha_transmissao(falha_transmissao),
    .db_tentativas(db_tentativas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] in;
    logic [3:0] est;
    logic [1:0] can;
    logic [1:0] tent;
    logic [5:0] pul;
  } vec_t;

  vec_t tab[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [6:0] i, logic [3:0] e,
                              logic [1:0] c, logic [1:0] t,
                              logic [5:0] p);
    mk = '{in: i, est: e, can: c, tent: t, pul: p};
  endfunction

  function automatic logic [5:0] pulses();
    pulses = {medir_dht11, zera_delay, conta_delay,
              receber_config, transmite_medida, transmite_erro};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic set_in(input logic [6:0] v);
    {start, fim_delay, definir_config, pronto_medida,
     erro_medida, pronto_config, pronto_transmissao_medida} = v;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    set_in(7'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_out(input logic [3:0] st, output int n);
    n = 0;
    while (db_estado == st && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc, exp_cyc, resp_cyc, ev, ek, ech, eat, d, r, k;
    int obs_k, b0;
    logic [6:0] resp_mask;
    logic       mfalha;
    logic [1:0] att;

    tab.push_back(mk(0,       4'd0,  0, 0, 0));
    tab.push_back(mk(S,       4'd1,  0, 0, MD));
    tab.push_back(mk(0,       4'd2,  0, 0, 0));
    tab.push_back(mk(0,       4'd2,  0, 0, 0));
    tab.push_back(mk(PM | EM, 4'd7,  0, 0, TM));
    tab.push_back(mk(0,       4'd8,  0, 0, 0));
    tab.push_back(mk(PT,      4'd9,  0, 0, 0));
    tab.push_back(mk(0,       4'd1,  1, 0, MD));
    tab.push_back(mk(0,       4'd2,  1, 0, 0));
    tab.push_back(mk(EM,      4'd11, 1, 0, 0));
    tab.push_back(mk(0,       4'd1,  1, 1, MD));
    tab.push_back(mk(0,       4'd2,  1, 1, 0));
    tab.push_back(mk(EM,      4'd10, 1, 1, TE));
    tab.push_back(mk(0,       4'd8,  1, 1, 0));
    tab.push_back(mk(PT,      4'd9,  1, 1, 0));
    tab.push_back(mk(0,       4'd1,  2, 0, MD));
    tab.push_back(mk(0,       4'd2,  2, 0, 0));
    tab.push_back(mk(PM,      4'd7,  2, 0, TM));
    tab.push_back(mk(0,       4'd8,  2, 0, 0));
    tab.push_back(mk(PT,      4'd9,  2, 0, 0));
    tab.push_back(mk(0,       4'd3,  0, 0, ZD));
    tab.push_back(mk(0,       4'd4,  0, 0, CD));
    tab.push_back(mk(0,       4'd4,  0, 0, CD));
    tab.push_back(mk(D,       4'd5,  0, 0, RC));
    tab.push_back(mk(0,       4'd6,  0, 0, 0));
    tab.push_back(mk(0,       4'd6,  0, 0, 0));
    tab.push_back(mk(PC,      4'd3,  0, 0, ZD));
    tab.push_back(mk(0,       4'd4,  0, 0, CD));
    tab.push_back(mk(F | D,   4'd1,  0, 0, MD));
    tab.push_back(mk(0,       4'd2,  0, 0, 0));

    tick();
    do_reset();
    chk("reset", {db_estado, canal, db_tentativas, pulses(),
                  falha_transmissao}, 0);

    foreach (tab[i]) begin
      set_in(tab[i].in);
      tick();
      chk($sformatf("vec%0d", i),
          {db_estado, canal, db_tentativas, pulses(), falha_transmissao},
          {tab[i].est, tab[i].can, tab[i].tent, tab[i].pul, 1'b0});
    end

    do_reset();
    set_in(S);
    tick();
    set_in(0);
    chk("to_mede", db_estado, 4'd1);
    tick();
    wait_out(4'd2, n);
    chk("to_med_cycles", n, T);
    chk("to_retenta", db_estado, 4'd11);
    tick();
    chk("to_mede2", {db_estado, db_tentativas}, {4'd1, 2'd1});
    tick();
    wait_out(4'd2, n);
    chk("to_med_cycles2", n, T);
    chk("to_terro", {db_estado, transmite_erro}, {4'd10, 1'b1});
    tick();
    wait_out(4'd8, n);
    chk("to_tx_cycles", n, T);
    chk("to_prox", {db_estado, falha_transmissao}, {4'd9, 1'b1});
    tick();
    chk("to_sticky", {db_estado, canal, falha_transmissao},
        {4'd1, 2'd1, 1'b1});
    tick();
    set_in(PM); tick(); set_in(0); tick();
    set_in(PT); tick(); set_in(0); tick();
    tick();
    set_in(PM); tick(); set_in(0); tick();
    chk("pre_rst", {db_estado, canal, falha_transmissao},
        {4'd8, 2'd2, 1'b1});
    reset = 1'b1;
    tick();
    chk("rst_mid", {db_estado, canal, falha_transmissao,
                    transmite_medida, transmite_erro, medir_dht11}, 0);
    reset = 1'b0;

    // Event-level model: each response decides the next expected pulse
    do_reset();
    cyc = 0; ev = 0; mfalha = 1'b0;
    resp_cyc = -1; resp_mask = 0;
    ek = 1; ech = 0; eat = 0; exp_cyc = 1;
    set_in(S);
    while (ev < 80) begin
      tick();
      cyc++;
      obs_k = 0;
      if ($countones(pulses() & (MD | ZD | TM | TE)) > 1) obs_k = 7;
      else if (medir_dht11) obs_k = 1;
      else if (transmite_medida) obs_k = 2;
      else if (transmite_erro) obs_k = 3;
      else if (zera_delay) obs_k = 4;
      if (obs_k != 0 || cyc == exp_cyc) begin
        att = (obs_k == 1) ? db_tentativas : 2'd0;
        b0 = bad;
        chk($sformatf("rnd_ev%0d", ev),
            {(cyc == exp_cyc), 3'(obs_k), canal, att, falha_transmissao},
            {1'b1, 3'(ek), 2'(ech), (ek == 1) ? 2'(eat) : 2'd0, mfalha});
        if (bad != b0) break;
        ev++;
        case (ek)
          1: begin
            r = $urandom_range(0, 9);
            if (r >= 8) begin
              d = T; resp_cyc = -1;
            end else begin
              d = $urandom_range(1, 4);
              resp_cyc = cyc + d;
              resp_mask = (r < 5) ? PM : (r == 5) ? (PM | EM) : EM;
            end
            if (r < 6) begin
              ek = 2; exp_cyc = cyc + d + 1;
            end else if (eat < M - 1) begin
              eat++; exp_cyc = cyc + d + 2;
            end else begin
              ek = 3; exp_cyc = cyc + d + 1;
            end
          end
          2, 3: begin
            if ($urandom_range(0, 7) == 0) begin
              d = T; resp_cyc = -1; mfalha = 1'b1;
            end else begin
              d = $urandom_range(1, 4);
              resp_cyc = cyc + d; resp_mask = PT;
            end
            exp_cyc = cyc + d + 2;
            eat = 0;
            if (ech == N - 1) begin
              ek = 4; ech = 0;
            end else begin
              ek = 1; ech++;
            end
          end
          default: begin
            k = $urandom_range(1, 3);
            resp_cyc = cyc + k;
            resp_mask = F | (($urandom_range(0, 1) == 1) ? D : 7'd0);
            ek = 1; ech = 0; eat = 0; exp_cyc = cyc + k + 1;
          end
        endcase
      end
      set_in((cyc == resp_cyc) ? resp_mask : 7'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
